dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single DRAM controller request/response FIFO port between two masters: port 0 (instruction fetch) and port 1 (data).
- Requests are granted round-robin into a one-entry registered output stage.
- The master ID of every accepted read goes into an in-order tag FIFO; the controller returns read data strictly in order, so each response pops the FIFO and is routed back to the master that issued it.
- Sits in the ui_clk domain, directly in front of dram_controller.

Parameters:
- ADDR_W, 27, request address width (matches app_addr).
- DATA_W, 128, line data width (matches app_wdf_data / app_rd_data).
- TAG_DEPTH, 4, maximum outstanding reads; must be a power of 2 and at least 2.

Ports:
- clk  in  1  ui_clk from dram_controller.
- sys_rst  in  1  synchronous, active-low reset.
- m0_req_en  in  1  port 0 request valid.
- m0_req_rdy  out  1  port 0 request accepted this cycle when high together with m0_req_en.
- m0_req_addr  in  ADDR_W  port 0 address.
- m0_req_cmd  in  1  port 0 command: 1 = read, 0 = write.
- m0_req_data  in  DATA_W  port 0 write data.
- m0_rsp_en  out  1  port 0 read data valid (single-cycle pulse, no backpressure).
- m0_rsp_data  out  DATA_W  port 0 read data.
- m1_*  same seven signals for port 1.
- s_req_en  out  1  to controller req_en.
- s_req_rdy  in  1  from controller req_rdy.
- s_req_addr  out  ADDR_W  to controller.
- s_req_cmd  out  1  to controller.
- s_req_data  out  DATA_W  to controller.
- s_rsp_en  in  1  from controller rsp_en.
- s_rsp_data  in  DATA_W  from controller rsp.data.
- err_unexpected_rsp  out  1  sticky: s_rsp_en arrived while the tag FIFO was empty.

Behaviour:
- Reset (sys_rst == 0 at posedge clk):
  - out_valid = 0, s_req_en = 0.
  - Tag FIFO emptied.
  - rr_last = 1, so port 0 wins first.
  - m*_rsp_en = 0, err_unexpected_rsp = 0.
  - Data registers are don't-care.
- Reset mid-operation: outstanding reads are discarded. Responses arriving after reset set err_unexpected_rsp; the masters must re-issue.
- Output stage:
  - Registers out_valid, addr, cmd, data, with s_req_en = out_valid.
  - A downstream handshake is s_req_en & s_req_rdy.
  - stage_free = !out_valid | s_req_rdy.
- Eligibility: port i is eligible when mi_req_en and (mi_req_cmd == 0, or tag_count < TAG_DEPTH).
  - tag_count includes the read sitting in the output stage, because the tag is pushed at acceptance.
- Grant (combinational):
  - No grant unless stage_free.
  - If both ports are eligible, grant the port != rr_last.
  - Otherwise grant the single eligible port.
  - mi_req_rdy = grant_i. It may depend combinationally on mi_req_en of both ports; a master must not make req_en depend on req_rdy.
- On a grant (posedge):
  - Load the output stage from the granted port and set out_valid = 1.
  - rr_last <= granted port.
  - If the command is a read, push the port ID into the tag FIFO.
- On a handshake with no new grant, out_valid <= 0.
- Back-to-back: when s_req_rdy is held high, one request moves per cycle. Latency from master accept to s_req_en is 1 cycle.
- Response path (registered, 1-cycle latency):
  - On s_rsp_en with the FIFO non-empty: pop the head tag t.
  - Next cycle: mt_rsp_en = 1 and mt_rsp_data = s_rsp_data; the other port's rsp_en = 0.
  - The rsp_data of both ports is driven from the same register; only rsp_en qualifies it.
  - On s_rsp_en with the FIFO empty: no pop, no rsp_en, err_unexpected_rsp <= 1 until reset.
- Simultaneous push and pop in one cycle is legal and leaves tag_count unchanged.
- A pop at tag_count == TAG_DEPTH frees a slot in the same cycle: eligibility uses tag_count - pop. The FIFO never overflows.
- Writes are posted: no response and no tag.
- Pointer wrap-around uses log2(TAG_DEPTH) bit pointers plus a (log2+1)-bit count.

Decomposition:
- Package dram_pkg:
  - ADDR_W and DATA_W constants.
  - typedef enum logic {CMD_WRITE = 0, CMD_READ = 1} dram_cmd_e.
  - typedef logic port_id_t.
- One natural sub-module, tag_fifo: synchronous FIFO with push, pop, full, empty, count.
  - Parameters: WIDTH = 1, DEPTH = TAG_DEPTH.
  - Reset: synchronous, active-low.

Test Plan:
- Both ports hold writes (m0 addr 0x100, m1 addr 0x200), s_req_rdy = 1.
  -> s_req_addr sequence 0x100, 0x200, 0x100, 0x200.
  -> The grants alternate every cycle.
  -> No rsp_en on either port.
- m0 reads 0x10; m1 reads 0x20, then 0x30. The controller returns D0, D1, D2 one cycle apart, 10 cycles later.
  -> m0_rsp_en with D0.
  -> m1_rsp_en with D1, then with D2.
  -> Each rsp_en lands exactly 1 cycle after its s_rsp_en.
- s_req_rdy = 0 for 5 cycles while m0 has a request pending.
  -> s_req_en stays high with stable addr/cmd/data.
  -> m0_req_rdy = 0 after the first accept.
  -> Resumes when s_req_rdy rises.
- Issue 4 reads from m1 with no responses (TAG_DEPTH = 4).
  -> 5th m1 read: m1_req_rdy = 0.
  -> An m0 write is still granted.
  -> In the cycle s_rsp_en = 1, m1_req_rdy = 1.
- s_rsp_en pulses with the tag FIFO empty.
  -> err_unexpected_rsp = 1 and stays high.
  -> Neither rsp_en fires.
- 2 reads outstanding, sys_rst = 0 for 1 cycle.
  -> s_req_en = 0, tag FIFO empty, and the first grant afterwards goes to m0.
  -> A later s_rsp_en sets err_unexpected_rsp.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and default widths for the DRAM front-end arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dram_pkg;

  // Defaults match app_addr and app_wdf_data / app_rd_data of the controller.
  localparam int ADDR_W = 27;
  localparam int DATA_W = 128;

  typedef enum logic {
    CMD_WRITE = 1'b0,
    CMD_READ  = 1'b1
  } dram_cmd_e;

  // Master identifier carried in the tag FIFO: 0 = instruction fetch, 1 = data.
  typedef logic port_id_t;

  localparam port_id_t PORT_IFETCH = 1'b0;
  localparam port_id_t PORT_DATA   = 1'b1;

endpackage

// File: rtl/dram_arbiter_tag_fifo.sv
// In-order FIFO of master IDs for reads still awaiting data from the controller.
// Latency: head is combinational from storage; push/pop take effect at the next edge.
// Backpressure: none internally; the caller keeps push off when full and pop off when empty.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_push_dat  write one entry at the tail
//   i_pop               retire the head entry
//   o_head_dat          oldest entry (valid while !o_empty)
//   o_full, o_empty     occupancy flags
//   o_count             number of stored entries, 0..DEPTH
module tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read once counted.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing the DRAM controller port between ifetch (m0) and data (m1).
// Latency: accept -> s_req_en 1 cycle; s_rsp_en -> m*_rsp_en 1 cycle.
// Backpressure: s_req_rdy low holds the output stage and withdraws m*_req_rdy; reads
//   also stall once TAG_DEPTH are outstanding. Responses have no backpressure.
//
// Ports:
//   clk, sys_rst           ui_clk, synchronous active-low reset
//   mX_req_en/rdy          master request handshake (rdy may depend on both req_en)
//   mX_req_addr/cmd/data   master request payload, cmd 1 = read, 0 = write
//   mX_rsp_en/data         read return to master, single-cycle pulse
//   s_req_*                request to the controller, s_req_en = stage occupied
//   s_rsp_en/data          in-order read data from the controller
//   err_unexpected_rsp     sticky: a response arrived with nothing outstanding
module dram_arbiter #(
  parameter int ADDR_W    = dram_pkg::ADDR_W,
  parameter int DATA_W    = dram_pkg::DATA_W,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              m0_req_en,
  output logic              m0_req_rdy,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic              m0_req_cmd,
  input  logic [DATA_W-1:0] m0_req_data,
  output logic              m0_rsp_en,
  output logic [DATA_W-1:0] m0_rsp_data,
  input  logic              m1_req_en,
  output logic              m1_req_rdy,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic              m1_req_cmd,
  input  logic [DATA_W-1:0] m1_req_data,
  output logic              m1_rsp_en,
  output logic [DATA_W-1:0] m1_rsp_data,
  output logic              s_req_en,
  input  logic              s_req_rdy,
  output logic [ADDR_W-1:0] s_req_addr,
  output logic              s_req_cmd,
  output logic [DATA_W-1:0] s_req_data,
  input  logic              s_rsp_en,
  input  logic [DATA_W-1:0] s_rsp_data,
  output logic              err_unexpected_rsp
);

  import dram_pkg::*;

  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  // Output stage and arbitration state
  logic              r_out_vld;
  logic [ADDR_W-1:0] r_out_addr;
  dram_cmd_e         r_out_cmd;
  logic [DATA_W-1:0] r_out_dat;
  port_id_t          r_rr_last;

  // Response stage
  logic              r_rsp_en0;
  logic              r_rsp_en1;
  logic [DATA_W-1:0] r_rsp_dat;
  logic              r_err;

  // Tag FIFO interface
  logic              w_tag_push;
  logic              w_tag_pop;
  port_id_t          w_tag_head;
  logic              w_tag_full;
  logic              w_tag_empty;
  logic [CNT_W-1:0]  w_tag_cnt;

  logic              w_stage_free;
  logic [CNT_W-1:0]  w_cnt_eff;
  logic              w_room;
  logic              w_elig0;
  logic              w_elig1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_gnt_any;
  port_id_t          w_gnt_port;
  logic [ADDR_W-1:0] w_sel_addr;
  dram_cmd_e         w_sel_cmd;
  logic [DATA_W-1:0] w_sel_dat;

  assign w_stage_free = !r_out_vld || s_req_rdy;

  // A response popping this cycle frees its slot for a read granted this cycle.
  assign w_tag_pop = s_rsp_en && !w_tag_empty;
  assign w_cnt_eff = w_tag_cnt - CNT_W'(w_tag_pop);
  assign w_room    = (w_cnt_eff < CNT_W'(TAG_DEPTH));

  assign w_elig0 = m0_req_en && ((m0_req_cmd == CMD_WRITE) || w_room);
  assign w_elig1 = m1_req_en && ((m1_req_cmd == CMD_WRITE) || w_room);

  // Contended cycles go to the port that did not win last; reset leaves
  // r_rr_last at the data port so ifetch wins first. Grants are held off while
  // in reset so a master never sees an accept that gets discarded.
  assign w_gnt0 = sys_rst && w_stage_free && w_elig0 && (!w_elig1 || (r_rr_last == PORT_DATA));
  assign w_gnt1 = sys_rst && w_stage_free && w_elig1 && (!w_elig0 || (r_rr_last == PORT_IFETCH));

  assign w_gnt_any  = w_gnt0 || w_gnt1;
  assign w_gnt_port = port_id_t'(w_gnt1);

  assign w_sel_addr = w_gnt1 ? m1_req_addr : m0_req_addr;
  assign w_sel_cmd  = dram_cmd_e'(w_gnt1 ? m1_req_cmd : m0_req_cmd);
  assign w_sel_dat  = w_gnt1 ? m1_req_data : m0_req_data;

  // Tag is pushed at acceptance so the read parked in the output stage already
  // counts against TAG_DEPTH. The full check only matters if eligibility and
  // FIFO state ever disagree; it keeps the head from being overwritten.
  assign w_tag_push = w_gnt_any && (w_sel_cmd == CMD_READ) && (!w_tag_full || w_tag_pop);

  tag_fifo #(
    .WIDTH (1),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk      (clk),
    .i_rst_n    (sys_rst),
    .i_push     (w_tag_push),
    .i_push_dat (w_gnt_port),
    .i_pop      (w_tag_pop),
    .o_head_dat (w_tag_head),
    .o_full     (w_tag_full),
    .o_empty    (w_tag_empty),
    .o_count    (w_tag_cnt)
  );

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      r_out_vld <= 1'b0;
      r_rr_last <= PORT_DATA;
      r_rsp_en0 <= 1'b0;
      r_rsp_en1 <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_gnt_any) begin
        r_out_vld <= 1'b1;
        r_rr_last <= w_gnt_port;
      end else if (s_req_rdy) begin
        // Handshake (or an already-empty stage) with nothing new to load.
        r_out_vld <= 1'b0;
      end
      r_rsp_en0 <= w_tag_pop && (w_tag_head == PORT_IFETCH);
      r_rsp_en1 <= w_tag_pop && (w_tag_head == PORT_DATA);
      if (s_rsp_en && w_tag_empty) r_err <= 1'b1;
    end
  end

  // Payload registers are qualified by r_out_vld / r_rsp_en*, so no reset.
  always_ff @(posedge clk) begin
    if (w_gnt_any) begin
      r_out_addr <= w_sel_addr;
      r_out_cmd  <= w_sel_cmd;
      r_out_dat  <= w_sel_dat;
    end
    if (w_tag_pop) r_rsp_dat <= s_rsp_data;
  end

  assign m0_req_rdy = w_gnt0;
  assign m1_req_rdy = w_gnt1;

  assign s_req_en   = r_out_vld;
  assign s_req_addr = r_out_addr;
  assign s_req_cmd  = r_out_cmd;
  assign s_req_data = r_out_dat;

  assign m0_rsp_en   = r_rsp_en0;
  assign m1_rsp_en   = r_rsp_en1;
  assign m0_rsp_data = r_rsp_dat;
  assign m1_rsp_data = r_rsp_dat;

  assign err_unexpected_rsp = r_err;

endmodule

// File: tb/tb_dram_arbiter.sv
`timescale 1ns/1ps
module tb_dram_arbiter;

  localparam int AW = 27;
  localparam int DW = 128;
  localparam int TD = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          sys_rst;
  logic          m0_req_en, m0_req_rdy, m0_req_cmd, m0_rsp_en;
  logic [AW-1:0] m0_req_addr;
  logic [DW-1:0] m0_req_data, m0_rsp_data;
  logic          m1_req_en, m1_req_rdy, m1_req_cmd, m1_rsp_en;
  logic [AW-1:0] m1_req_addr;
  logic [DW-1:0] m1_req_data, m1_rsp_data;
  logic          s_req_en, s_req_rdy, s_req_cmd, s_rsp_en;
  logic [AW-1:0] s_req_addr;
  logic [DW-1:0] s_req_data, s_rsp_data;
  logic          err_unexpected_rsp;

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .m0_req_en(m0_req_en), .m0_req_rdy(m0_req_rdy), .m0_req_addr(m0_req_addr),
    .m0_req_cmd(m0_req_cmd), .m0_req_data(m0_req_data),
    .m0_rsp_en(m0_rsp_en), .m0_rsp_data(m0_rsp_data),
    .m1_req_en(m1_req_en), .m1_req_rdy(m1_req_rdy), .m1_req_addr(m1_req_addr),
    .m1_req_cmd(m1_req_cmd), .m1_req_data(m1_req_data),
    .m1_rsp_en(m1_rsp_en), .m1_rsp_data(m1_rsp_data),
    .s_req_en(s_req_en), .s_req_rdy(s_req_rdy), .s_req_addr(s_req_addr),
    .s_req_cmd(s_req_cmd), .s_req_data(s_req_data),
    .s_rsp_en(s_rsp_en), .s_rsp_data(s_rsp_data),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  typedef struct { logic [AW-1:0] addr; logic cmd; logic [DW-1:0] dat; } req_s;
  typedef struct { logic [DW-1:0] dat; int due; } rsp_s;

  // Reference model: per-master pending requests, the request the controller
  // should currently see, the controller's in-flight reads, and the port IDs
  // of reads not yet answered (oldest first).
  req_s mq0[$], mq1[$], dq[$];
  rsp_s cq[$];
  int   tagq[$];
  int   rr_last;
  logic exp_r0, exp_r1, exp_err;
  logic [DW-1:0] exp_rdat;

  int   checks = 0, errors = 0;
  int   cyc = 0, last_due = 0, lat_min = 10, lat_max = 10;
  bit   auto_ctl = 1'b1, man_rsp = 1'b0;
  int   rcv0 = 0, rcv1 = 0, oacc0 = 0, oacc1 = 0;
  logic [AW-1:0] obs_addr;
  logic obs_rdy0, obs_rdy1;
  logic [AW-1:0] seen [4];
  logic [AW-1:0] wexp [4];

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic q_push(input int port, input logic [AW-1:0] a, input logic c);
    req_s r;
    r.addr = a; r.cmd = c; r.dat = rnd128();
    if (port == 0) mq0.push_back(r); else mq1.push_back(r);
  endtask

  task automatic drive_masters();
    m0_req_en = (mq0.size() > 0);
    if (mq0.size() > 0) begin
      m0_req_addr = mq0[0].addr; m0_req_cmd = mq0[0].cmd; m0_req_data = mq0[0].dat;
    end
    m1_req_en = (mq1.size() > 0);
    if (mq1.size() > 0) begin
      m1_req_addr = mq1[0].addr; m1_req_cmd = mq1[0].cmd; m1_req_data = mq1[0].dat;
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step();
    bit   sf, pop, e0, e1, g0, g1;
    int   cnt, t, d;
    req_s r;
    rsp_s c;
    drive_masters();
    s_rsp_en   = 1'b0;
    s_rsp_data = rnd128();
    if (sys_rst && (man_rsp || (auto_ctl && cq.size() > 0 && cq[0].due <= cyc))) begin
      s_rsp_en = 1'b1;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        s_rsp_data = c.dat;
      end
    end
    man_rsp = 1'b0;
    #1;
    chk("s_req_en", s_req_en, dq.size() > 0);
    if (dq.size() > 0) begin
      chk("s_req_addr", s_req_addr, dq[0].addr);
      chk("s_req_cmd", s_req_cmd, dq[0].cmd);
      chk("s_req_data", s_req_data, dq[0].dat);
    end
    chk("m0_rsp_en", m0_rsp_en, exp_r0);
    chk("m1_rsp_en", m1_rsp_en, exp_r1);
    if (exp_r0) chk("m0_rsp_data", m0_rsp_data, exp_rdat);
    if (exp_r1) chk("m1_rsp_data", m1_rsp_data, exp_rdat);
    chk("err_unexpected_rsp", err_unexpected_rsp, exp_err);
    obs_addr = s_req_addr; obs_rdy0 = m0_req_rdy; obs_rdy1 = m1_req_rdy;
    if (m0_rsp_en === 1'b1) rcv0++;
    if (m1_rsp_en === 1'b1) rcv1++;
    if (m0_req_en && m0_req_rdy === 1'b1) oacc0++;
    if (m1_req_en && m1_req_rdy === 1'b1) oacc1++;

    sf  = (dq.size() == 0) || s_req_rdy;
    pop = s_rsp_en && (tagq.size() > 0);
    cnt = tagq.size() - int'(pop);
    e0  = (mq0.size() > 0) && (mq0[0].cmd == 1'b0 || cnt < TD);
    e1  = (mq1.size() > 0) && (mq1[0].cmd == 1'b0 || cnt < TD);
    g0  = sys_rst && sf && e0 && (!e1 || rr_last == 1);
    g1  = sys_rst && sf && e1 && (!e0 || rr_last == 0);
    if (sys_rst) begin
      chk("m0_req_rdy", m0_req_rdy, g0);
      chk("m1_req_rdy", m1_req_rdy, g1);
    end

    if (!sys_rst) begin
      dq.delete(); tagq.delete();
      rr_last = 1; exp_r0 = 1'b0; exp_r1 = 1'b0; exp_err = 1'b0;
    end else begin
      if (dq.size() > 0 && s_req_rdy) begin
        r = dq.pop_front();
        if (r.cmd) begin
          d = cyc + int'($urandom_range(lat_min, lat_max));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          c.dat = rnd128(); c.due = d;
          cq.push_back(c);
        end
      end
      exp_r0 = 1'b0; exp_r1 = 1'b0;
      if (pop) begin
        t = tagq.pop_front();
        exp_r0 = (t == 0); exp_r1 = (t == 1); exp_rdat = s_rsp_data;
      end else if (s_rsp_en) begin
        exp_err = 1'b1;
      end
      if (g0) begin
        r = mq0.pop_front(); dq.push_back(r); rr_last = 0;
        if (r.cmd) tagq.push_back(0);
      end
      if (g1) begin
        r = mq1.pop_front(); dq.push_back(r); rr_last = 1;
        if (r.cmd) tagq.push_back(1);
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((mq0.size() + mq1.size() + dq.size() + tagq.size() + cq.size() > 0
            || exp_r0 || exp_r1) && n < lim) begin
      step();
      n++;
    end
    checks++;
    assert (n < lim) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected<%0d", n, lim);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b0; s_req_rdy = 1'b0; s_rsp_en = 1'b0; s_rsp_data = '0;
    m0_req_en = 1'b0; m0_req_addr = '0; m0_req_cmd = 1'b0; m0_req_data = '0;
    m1_req_en = 1'b0; m1_req_addr = '0; m1_req_cmd = 1'b0; m1_req_data = '0;
    rr_last = 1; exp_r0 = 1'b0; exp_r1 = 1'b0; exp_err = 1'b0; exp_rdat = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst s_req_en", s_req_en, 1'b0);
    chk("rst m0_rsp_en", m0_rsp_en, 1'b0);
    chk("rst m1_rsp_en", m1_rsp_en, 1'b0);
    chk("rst err", err_unexpected_rsp, 1'b0);
    sys_rst = 1'b1;

    // Contending writes alternate, m0 first after reset.
    for (int i = 0; i < 4; i++) begin
      q_push(0, 27'h100, 1'b0);
      q_push(1, 27'h200, 1'b0);
    end
    wexp[0] = 27'h100; wexp[1] = 27'h200; wexp[2] = 27'h100; wexp[3] = 27'h200;
    s_req_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) seen[i-1] = obs_addr;
    end
    for (int i = 0; i < 4; i++) chk("wr_alt_addr", seen[i], wexp[i]);
    drain(50);
    chk("wr_no_rsp", rcv0 + rcv1, 0);

    // Reads from both masters come back to their owners in order.
    rcv0 = 0; rcv1 = 0;
    q_push(0, 27'h10, 1'b1);
    q_push(1, 27'h20, 1'b1);
    q_push(1, 27'h30, 1'b1);
    drain(100);
    chk("rd_m0_count", rcv0, 1);
    chk("rd_m1_count", rcv1, 2);

    // Controller backpressure holds the stage and blocks further accepts.
    oacc0 = 0;
    s_req_rdy = 1'b0;
    q_push(0, 27'h300, 1'b0);
    q_push(0, 27'h304, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) begin
        chk("stall_addr", obs_addr, 27'h300);
        chk("stall_m0_rdy", obs_rdy0, 1'b0);
      end
    end
    chk("stall_accepts", oacc0, 1);
    s_req_rdy = 1'b1;
    drain(50);

    // Tag FIFO full: fifth read waits, write still passes, a pop frees a slot.
    auto_ctl = 1'b0; lat_min = 1; lat_max = 6;
    oacc1 = 0;
    for (int i = 0; i < 5; i++) q_push(1, AW'(32'h400 + 4 * i), 1'b1);
    repeat (5) step();
    chk("full_m1_rdy", obs_rdy1, 1'b0);
    chk("full_m1_accepts", oacc1, 4);
    q_push(0, 27'h500, 1'b0);
    step();
    chk("full_m0_wr_rdy", obs_rdy0, 1'b1);
    chk("full_m1_still_blocked", obs_rdy1, 1'b0);
    man_rsp = 1'b1;
    step();
    chk("pop_frees_m1_rdy", obs_rdy1, 1'b1);
    auto_ctl = 1'b1;
    drain(100);

    // Response with nothing outstanding.
    rcv0 = 0; rcv1 = 0;
    man_rsp = 1'b1;
    step();
    repeat (3) step();
    chk("unexp_err_sticky", err_unexpected_rsp, 1'b1);
    chk("unexp_no_rsp", rcv0 + rcv1, 0);

    // Reset with two reads outstanding.
    auto_ctl = 1'b0;
    q_push(0, 27'h600, 1'b1);
    q_push(1, 27'h700, 1'b1);
    repeat (3) step();
    sys_rst = 1'b0; s_req_rdy = 1'b0;
    step();
    sys_rst = 1'b1; s_req_rdy = 1'b1;
    chk("post_rst_s_req_en", s_req_en, 1'b0);
    chk("post_rst_err", err_unexpected_rsp, 1'b0);
    q_push(0, 27'h800, 1'b0);
    q_push(1, 27'h900, 1'b0);
    step();
    chk("post_rst_m0_first", obs_rdy0, 1'b1);
    chk("post_rst_m1_waits", obs_rdy1, 1'b0);
    man_rsp = 1'b1;
    step();
    step();
    chk("stale_rsp_err", err_unexpected_rsp, 1'b1);
    auto_ctl = 1'b1;
    drain(50);

    // Randomized traffic with random controller readiness and latency.
    lat_min = 1; lat_max = 12;
    for (int i = 0; i < 600; i++) begin
      if (mq0.size() == 0 && $urandom_range(0, 99) < 60)
        q_push(0, AW'($urandom), 1'($urandom_range(0, 1)));
      if (mq1.size() == 0 && $urandom_range(0, 99) < 60)
        q_push(1, AW'($urandom), 1'($urandom_range(0, 1)));
      s_req_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    s_req_rdy = 1'b1;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
